// File: rtl/mem_pkg.sv
// Shared state encoding, line layout and default geometry for the L1 data cache.
package mem_pkg;

  localparam int unsigned DEF_WAYS        = 4;
  localparam int unsigned DEF_SETS        = 8;
  localparam int unsigned DEF_BLOCK_BYTES = 16;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_TAG_W       = DEF_ADDR_W - $clog2(DEF_SETS) - $clog2(DEF_BLOCK_BYTES);

  typedef enum logic [2:0] {
    LOOKUP,
    WRITEBACK,
    ALLOCATE,
    WRITE_THROUGH,
    RESPOND
  } state_t;

  // Logical view of one cache line at the default geometry.
  typedef struct packed {
    logic                           valid;
    logic                           dirty;
    logic [DEF_TAG_W-1:0]           tag;
    logic [8*DEF_BLOCK_BYTES-1:0]   data;
  } line_t;

endpackage

// File: rtl/l1_lru.sv
// True-LRU bookkeeping: per-set per-way age counters, victim selection and touch update.
module l1_lru import mem_pkg::*; #(
  parameter  int unsigned WAYS  = DEF_WAYS,
  parameter  int unsigned SETS  = DEF_SETS,
  localparam int unsigned WAY_W = $clog2(WAYS),
  localparam int unsigned SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SET_W-1:0] set_idx,
  input  logic [WAYS-1:0]  valid_mask,
  input  logic             touch_en,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim_way
);

  logic [WAY_W-1:0] age [SETS][WAYS];
  logic [WAY_W-1:0] touch_age;

  assign touch_age = age[set_idx][touch_way];

  // Ages always form a permutation of 0..WAYS-1, so the oldest way is unique.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WAY_W'(w);
    end else if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          age[set_idx][w] <= '0;
        else if (age[set_idx][w] < touch_age)
          age[set_idx][w] <= age[set_idx][w] + 1'b1;
      end
    end
  end

  // Lowest-index invalid way wins over the oldest way.
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[set_idx][w] == WAY_W'(WAYS - 1))
        victim_way = WAY_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_mask[w])
        victim_way = WAY_W'(w);
  end

endmodule

// File: rtl/l1_dcache_wb.sv
// Set-associative L1 data cache with byte CPU port, line-wide memory port and true-LRU replacement.
// Define DCACHE_WRITE_BACK_EN for write-back operation; otherwise every store writes through.
module l1_dcache_wb import mem_pkg::*; #(
  parameter  int unsigned WAYS        = DEF_WAYS,
  parameter  int unsigned SETS        = DEF_SETS,
  parameter  int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter  int unsigned ADDR_W      = DEF_ADDR_W,
  localparam int unsigned BLOCK_BITS  = 8 * BLOCK_BYTES,
  localparam int unsigned OFF_W       = $clog2(BLOCK_BYTES),
  localparam int unsigned SET_W       = $clog2(SETS),
  localparam int unsigned TAG_W       = ADDR_W - SET_W - OFF_W,
  localparam int unsigned WAY_W       = $clog2(WAYS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpu_valid_i,
  input  logic                  cpu_wen_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [7:0]            cpu_wdata_i,
  output logic                  cpu_ready_o,
  output logic [7:0]            cpu_rdata_o,
  output logic                  mem_valid_o,
  output logic                  mem_wen_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i
);

`ifdef DCACHE_WRITE_BACK_EN
  localparam bit WRITE_BACK = 1'b1;
`else
  localparam bit WRITE_BACK = 1'b0;
`endif

  state_t state, state_next;

  logic [TAG_W-1:0] req_tag;
  logic [SET_W-1:0] req_set;
  logic [OFF_W-1:0] req_off;

  logic [BLOCK_BITS-1:0] data_arr  [WAYS][SETS];
  logic [TAG_W-1:0]      tag_arr   [WAYS][SETS];
  logic [WAYS-1:0]       valid_arr [SETS];
  logic [WAYS-1:0]       dirty_arr [SETS];

  logic [WAY_W-1:0]      acc_way, acc_way_next;
  logic [WAY_W-1:0]      hit_way, victim_way, line_way, touch_way;
  logic                  hit, line_we, fill, set_dirty, touch_en;
  logic [BLOCK_BITS-1:0] hit_line, acc_line, line_wdata;

  // The CPU holds its request until cpu_ready_o, so the live address is used throughout.
  assign {req_tag, req_set, req_off} = cpu_addr_i;

  assign hit_line = data_arr[hit_way][req_set];
  assign acc_line = data_arr[acc_way][req_set];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_arr[req_set][w] && tag_arr[w][req_set] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  l1_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .set_idx    (req_set),
    .valid_mask (valid_arr[req_set]),
    .touch_en   (touch_en),
    .touch_way  (touch_way),
    .victim_way (victim_way)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= LOOKUP;
      acc_way <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
      end
    end else begin
      state   <= state_next;
      acc_way <= acc_way_next;
      if (line_we) begin
        valid_arr[req_set][line_way] <= 1'b1;
        dirty_arr[req_set][line_way] <= set_dirty;
      end
    end
  end

  // Line contents and tags carry no reset; valid bits guard them.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      data_arr[line_way][req_set] <= line_wdata;
      if (fill)
        tag_arr[line_way][req_set] <= req_tag;
    end
  end

  always_comb begin
    state_next   = state;
    acc_way_next = acc_way;
    line_we      = 1'b0;
    line_way     = acc_way;
    line_wdata   = acc_line;
    fill         = 1'b0;
    set_dirty    = 1'b0;
    touch_en     = 1'b0;
    touch_way    = acc_way;
    cpu_ready_o  = 1'b0;
    cpu_rdata_o  = '0;
    mem_valid_o  = 1'b0;
    mem_wen_o    = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;

    unique case (state)
      LOOKUP: begin
        if (cpu_valid_i) begin
          if (hit) begin
            acc_way_next = hit_way;
            touch_en     = 1'b1;
            touch_way    = hit_way;
            state_next   = RESPOND;
            if (cpu_wen_i) begin
              line_we    = 1'b1;
              line_way   = hit_way;
              line_wdata = hit_line;
              line_wdata[{req_off, 3'b000} +: 8] = cpu_wdata_i;
              set_dirty  = WRITE_BACK;
              state_next = WRITE_BACK ? RESPOND : WRITE_THROUGH;
            end
          end else begin
            acc_way_next = victim_way;
            state_next   = (valid_arr[req_set][victim_way] && dirty_arr[req_set][victim_way])
                           ? WRITEBACK : ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        mem_valid_o = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = {tag_arr[acc_way][req_set], req_set, {OFF_W{1'b0}}};
        mem_wdata_o = acc_line;
        if (mem_ready_i)
          state_next = ALLOCATE;
      end

      ALLOCATE: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = {req_tag, req_set, {OFF_W{1'b0}}};
        if (mem_ready_i) begin
          line_we    = 1'b1;
          fill       = 1'b1;
          line_wdata = mem_rdata_i;
          if (cpu_wen_i)
            line_wdata[{req_off, 3'b000} +: 8] = cpu_wdata_i;
          set_dirty  = WRITE_BACK && cpu_wen_i;
          touch_en   = 1'b1;
          state_next = (!WRITE_BACK && cpu_wen_i) ? WRITE_THROUGH : RESPOND;
        end
      end

      WRITE_THROUGH: begin
        mem_valid_o = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = {req_tag, req_set, {OFF_W{1'b0}}};
        mem_wdata_o = acc_line;
        if (mem_ready_i)
          state_next = RESPOND;
      end

      RESPOND: begin
        cpu_ready_o = 1'b1;
        cpu_rdata_o = acc_line[{req_off, 3'b000} +: 8];
        state_next  = LOOKUP;
      end

      default: state_next = LOOKUP;
    endcase
  end

endmodule

// File: doc/l1_dcache_wb.md
L1_DCACHE_WB -- requirements
Module: l1_dcache_wb

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity; power of two, >=2.
REQ-002 SHALL have parameter SETS, default 8, sets per way; power of two.
REQ-003 SHALL have parameter BLOCK_BYTES, default 16, line size; power of two; BLOCK_BITS = 8*BLOCK_BYTES.
REQ-004 SHALL have parameter ADDR_W, default 32, address width; TAG_W = ADDR_W - log2(SETS) - log2(BLOCK_BYTES).
REQ-005 SHALL have ports, in this order:
  clk_i  in  1  clock; single clock domain.
  rst_ni  in  1  reset; asynchronous, active-low.
  cpu_valid_i  in  1  CPU request; held until cpu_ready_o is seen.
  cpu_wen_i  in  1  1 = byte store, 0 = byte load.
  cpu_addr_i  in  ADDR_W  byte address; held with cpu_valid_i.
  cpu_wdata_i  in  8  store byte.
  cpu_ready_o  out  1  one-cycle completion pulse.
  cpu_rdata_o  out  8  load byte; valid while cpu_ready_o=1.
  mem_valid_o  out  1  memory request.
  mem_wen_o  out  1  1 = line write, 0 = line read.
  mem_addr_o  out  ADDR_W  line-aligned address; low log2(BLOCK_BYTES) bits zero.
  mem_wdata_o  out  BLOCK_BITS  line write data.
  mem_ready_i  in  1  one-cycle memory completion; qualifies mem_rdata_i.
  mem_rdata_i  in  BLOCK_BITS  line read data; byte k at bits [8k+7:8k].

Function
REQ-006 Address split SHALL be: tag = top TAG_W bits, set = next log2(SETS) bits, offset = low log2(BLOCK_BYTES) bits.
REQ-007 FSM states SHALL be LOOKUP, WRITEBACK, ALLOCATE, WRITE_THROUGH, RESPOND; reset state LOOKUP.
REQ-008 LOOKUP with cpu_valid_i=0 SHALL remain in LOOKUP with no side effects.
REQ-009 LOOKUP hit SHALL be any way in the set with valid=1 and matching tag; next state RESPOND.
REQ-010 On a hit store, the offset byte SHALL be merged into the line on the LOOKUP->next-state edge.
REQ-011 LOOKUP miss SHALL pick a victim: lowest-index invalid way, else the LRU way.
REQ-012 After a miss, next state SHALL be WRITEBACK if the victim is valid and dirty, else ALLOCATE.
REQ-013 WRITEBACK SHALL drive mem_valid_o=1, mem_wen_o=1, mem_addr_o={victim tag,set,0}, mem_wdata_o=victim line.
REQ-014 WRITEBACK SHALL go to ALLOCATE on the cycle mem_ready_i=1.
REQ-015 ALLOCATE SHALL drive mem_valid_o=1, mem_wen_o=0, mem_addr_o={tag,set,0}.
REQ-016 On mem_ready_i=1, ALLOCATE SHALL write mem_rdata_i into the victim with valid=1, dirty=0 and the new tag.
REQ-017 A store miss SHALL merge cpu_wdata_i into the filled line in the same write.
REQ-018 Memory outputs SHALL stay stable while mem_valid_o=1 and mem_ready_i=0 (unbounded wait).
REQ-019 mem_valid_o SHALL be 0 in LOOKUP and RESPOND.
REQ-020 RESPOND SHALL assert cpu_ready_o=1 for exactly one cycle, then return to LOOKUP.
REQ-021 Hit latency SHALL be 2 cycles from cpu_valid_i sampled in LOOKUP to cpu_ready_o.
REQ-022 Replacement SHALL be true LRU via per-set per-way age counters of log2(WAYS) bits.
REQ-023 On a hit or fill, the accessed way's age SHALL become 0; ages lower than its old age SHALL increment; others hold.
REQ-024 cpu_rdata_o SHALL be the offset byte of the accessed line, updated with any store; 0 outside RESPOND.

Reset
REQ-025 Asserting rst_ni low SHALL immediately force: state LOOKUP, all valid and dirty bits 0, way w age = w, cpu_ready_o=0, mem_valid_o=0, mem_wen_o=0.
REQ-026 Reset mid-transaction SHALL abandon it; the CPU SHALL reissue the request.
REQ-027 Data and tag arrays SHALL NOT be reset.

Configuration
REQ-028 Macro DCACHE_WRITE_BACK_EN defined: write-back; stores set dirty=1; WRITE_THROUGH is unreachable.
REQ-029 Macro DCACHE_WRITE_BACK_EN undefined: write-through.
REQ-030 In write-through mode, every store (hit, or miss after ALLOCATE) SHALL go to WRITE_THROUGH.
REQ-031 WRITE_THROUGH SHALL write the merged line to {tag,set,0}, then go to RESPOND on mem_ready_i=1.
REQ-032 In write-through mode, dirty SHALL stay 0 and WRITEBACK is unreachable.

Structure
REQ-033 mem_pkg SHALL hold the state enum, the line struct (valid, dirty, tag, data) and the parameter defaults.
REQ-034 LRU bookkeeping SHALL be a sub-module l1_lru (per-set ages, victim select, touch update).

Verification (WAYS=4, SETS=8, BLOCK_BYTES=16; set = addr[6:4])
REQ-035 Cold load 0x104, memory byte 4 = 0xAB -> one read at mem_addr_o=0x100; cpu_rdata_o=0xAB.
REQ-036 Repeat the 0x104 load -> no mem_valid_o; cpu_ready_o 2 cycles after request.
REQ-037 Write-back build: store 0x5A to 0x104, then load 0x104 -> no memory traffic; load returns 0x5A.
REQ-038 Write-back build: dirty 0x000, then touch 0x080, 0x100, 0x180, then load 0x200 -> write to 0x000, then read 0x200.
REQ-039 Write-through build: store 0x77 to 0x20C -> memory write at 0x200 with byte 12 = 0x77; dirty stays 0.
REQ-040 Reset during ALLOCATE with mem_ready_i held low for 5 cycles -> memory outputs stable before reset; mem_valid_o=0 at reset assertion; the next load of the same address misses.
